// File: rtl/pong_pkg.sv
// Shared types and default constants for the Pong game sequencer.
// Optional rally speed-up is enabled with the RALLY_SPEEDUP_EN macro.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    localparam int DEF_WIN_SCORE    = 7;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_POINT_FRAMES = 90;
    localparam int DEF_SCORE_W      = 4;

endpackage

// File: rtl/pong_game_ctrl_edge_sync.sv
// Optional 2-flop synchronizer followed by a one-cycle edge pulse.
// FALL selects falling-edge detection; SYNC adds the metastability flop.
module edge_sync #(
    parameter bit SYNC = 1'b1,
    parameter bit FALL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic smp;
    logic cur_q;
    logic prev_q;

    if (SYNC) begin : g_sync
        logic meta_q;
        // First synchronizer stage for asynchronous inputs
        always_ff @(posedge clk) begin
            if (reset) meta_q <= 1'b0;
            else       meta_q <= din;
        end
        assign smp = meta_q;
    end else begin : g_direct
        assign smp = din;
    end

    // Current sample and previous-sample history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= smp;
            prev_q <= cur_q;
        end
    end

    assign pulse = FALL ? (prev_q & ~cur_q) : (cur_q & ~prev_q);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: idle, serve countdown, rally, point pause, game over.
// Define RALLY_SPEEDUP_EN to enable paddle-hit driven speed levels.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES = DEF_POINT_FRAMES,
    parameter int SCORE_W      = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start_btn,
    input  logic               p1score,
    input  logic               p2score,
    input  logic               paddle_hit,
    output logic               ball_en,
    output logic               ball_serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] p1_points,
    output logic [SCORE_W-1:0] p2_points,
    output logic [1:0]         winner,
    output logic [2:0]         game_state,
    output logic [1:0]         speed_level
);

    localparam int MAX_FR = (SERVE_FRAMES > POINT_FRAMES) ?
                            SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W  = $clog2(MAX_FR + 1);

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    logic frame_tick;
    logic start_evt;
    logic p1_evt;
    logic p2_evt;

    edge_sync #(.SYNC(1'b1), .FALL(1'b0)) u_start (
        .clk(clk), .reset(reset), .din(start_btn), .pulse(start_evt)
    );
    edge_sync #(.SYNC(1'b0), .FALL(1'b1)) u_vsync (
        .clk(clk), .reset(reset), .din(vsync), .pulse(frame_tick)
    );
    edge_sync #(.SYNC(1'b0), .FALL(1'b0)) u_p1 (
        .clk(clk), .reset(reset), .din(p1score), .pulse(p1_evt)
    );
    edge_sync #(.SYNC(1'b0), .FALL(1'b0)) u_p2 (
        .clk(clk), .reset(reset), .din(p2score), .pulse(p2_evt)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    winner_e            win_q, win_d;
    logic               dir_q, dir_d;
    logic               en_q, en_d;
    logic               serve_q, serve_d;

    // Next-state and next-output computation for the match sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        dir_d   = dir_q;
        serve_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_evt) begin
                    p1_d    = '0;
                    p2_d    = '0;
                    win_d   = WIN_NONE;
                    dir_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d   = '0;
                        serve_d = 1'b1;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (p1_evt && !p2_evt) begin
                    p1_d  = p1_q + 1'b1;
                    dir_d = 1'b1;
                    if (p1_d == WIN_VAL) begin
                        win_d   = WIN_P1;
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_POINT;
                    end
                end else if (p2_evt && !p1_evt) begin
                    p2_d  = p2_q + 1'b1;
                    dir_d = 1'b0;
                    if (p2_d == WIN_VAL) begin
                        win_d   = WIN_P2;
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        en_d = (state_d == ST_PLAY);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= WIN_NONE;
            dir_q   <= 1'b0;
            en_q    <= 1'b0;
            serve_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            serve_q <= serve_d;
        end
    end

`ifdef RALLY_SPEEDUP_EN
    logic [3:0] rally_q, rally_d;

    // Rally hit counter, restarted at every serve countdown
    always_comb begin
        rally_d = rally_q;
        if (state_d == ST_SERVE && state_q != ST_SERVE) begin
            rally_d = '0;
        end else if (state_q == ST_PLAY && paddle_hit &&
                     rally_q != 4'd15) begin
            rally_d = rally_q + 1'b1;
        end
    end

    // Rally counter register
    always_ff @(posedge clk) begin
        if (reset) rally_q <= '0;
        else       rally_q <= rally_d;
    end

    assign speed_level = rally_q[3:2];
`else
    logic unused_paddle_hit;
    assign unused_paddle_hit = paddle_hit;
    assign speed_level       = 2'b00;
`endif

    assign ball_en    = en_q;
    assign ball_serve = serve_q;
    assign serve_dir  = dir_q;
    assign p1_points  = p1_q;
    assign p2_points  = p2_q;
    assign winner     = win_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl with shortened frame counts.
// Expectations are queued with stimulus and drained against DUT outputs.
module tb_pong_game_ctrl;

    localparam int SW = 4;

    localparam int S_STATE = 0;
    localparam int S_EN    = 1;
    localparam int S_SERVE = 2;
    localparam int S_DIR   = 3;
    localparam int S_P1    = 4;
    localparam int S_P2    = 5;
    localparam int S_WIN   = 6;
    localparam int S_SPD   = 7;
    localparam int S_SCNT  = 8;
    localparam int S_BAD   = 9;
    localparam int S_AT    = 10;

`ifdef RALLY_SPEEDUP_EN
    localparam int SPD5 = 1;
`else
    localparam int SPD5 = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b1;
    logic          start_btn = 1'b0;
    logic          p1score = 1'b0;
    logic          p2score = 1'b0;
    logic          paddle_hit = 1'b0;
    logic          ball_en;
    logic          ball_serve;
    logic          serve_dir;
    logic [SW-1:0] p1_points;
    logic [SW-1:0] p2_points;
    logic [1:0]    winner;
    logic [2:0]    game_state;
    logic [1:0]    speed_level;

    int n_vec = 0;
    int n_err = 0;
    int serve_cnt = 0;
    int bad_serve = 0;
    int serve_at = -1;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];

    pong_game_ctrl #(
        .WIN_SCORE(2), .SERVE_FRAMES(3),
        .POINT_FRAMES(2), .SCORE_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .start_btn(start_btn), .p1score(p1score),
        .p2score(p2score), .paddle_hit(paddle_hit),
        .ball_en(ball_en), .ball_serve(ball_serve),
        .serve_dir(serve_dir), .p1_points(p1_points),
        .p2_points(p2_points), .winner(winner),
        .game_state(game_state), .speed_level(speed_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ball_serve === 1'b1) begin
            serve_cnt++;
            if (game_state !== 3'd2) bad_serve++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_v(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic int obs(input int sel);
        case (sel)
            S_STATE: return int'(game_state);
            S_EN:    return int'(ball_en);
            S_SERVE: return int'(ball_serve);
            S_DIR:   return int'(serve_dir);
            S_P1:    return int'(p1_points);
            S_P2:    return int'(p2_points);
            S_WIN:   return int'(winner);
            S_SPD:   return int'(speed_level);
            S_SCNT:  return serve_cnt;
            S_BAD:   return bad_serve;
            S_AT:    return serve_at;
            default: return -99;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        step(3);
        vsync = 1'b1;
        step(3);
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step(4);
        start_btn = 1'b0;
        step(2);
    endtask

    task automatic pulse_score(input bit p1, input bit p2);
        p1score = p1;
        p2score = p2;
        step(3);
        p1score = 1'b0;
        p2score = 1'b0;
        step(2);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            paddle_hit = 1'b1;
            step(1);
            paddle_hit = 1'b0;
            step(1);
        end
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        step(1);
        expect_v("rst_state", S_STATE, 0);
        expect_v("rst_en", S_EN, 0);
        expect_v("rst_serve", S_SERVE, 0);
        expect_v("rst_dir", S_DIR, 0);
        expect_v("rst_p1", S_P1, 0);
        expect_v("rst_p2", S_P2, 0);
        expect_v("rst_win", S_WIN, 0);
        expect_v("rst_spd", S_SPD, 0);
        drain();

        frame();
        expect_v("idle_no_start", S_STATE, 0);
        drain();

        press_start();
        expect_v("start_serve", S_STATE, 1);
        drain();
        frame();
        frame();
        expect_v("two_frames_serve", S_STATE, 1);
        expect_v("two_frames_noserve", S_SCNT, 0);
        drain();
        vsync = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            if (ball_serve === 1'b1 && serve_at < 0) serve_at = c;
        end
        vsync = 1'b1;
        step(3);
        expect_v("serve_cycle", S_AT, 2);
        expect_v("serve_once", S_SCNT, 1);
        expect_v("play_state", S_STATE, 2);
        expect_v("play_en", S_EN, 1);
        expect_v("play_serve_low", S_SERVE, 0);
        drain();

        p2score = 1'b1;
        step(3);
        expect_v("p2_pts", S_P2, 1);
        expect_v("p2_dir", S_DIR, 0);
        expect_v("p2_point", S_STATE, 3);
        expect_v("p2_en_off", S_EN, 0);
        drain();
        frame();
        expect_v("point_wait", S_STATE, 3);
        drain();
        frame();
        expect_v("point_to_serve", S_STATE, 1);
        drain();
        frame();
        frame();
        frame();
        expect_v("held_p2_once", S_P2, 1);
        expect_v("replay_state", S_STATE, 2);
        expect_v("replay_serves", S_SCNT, 2);
        drain();
        p2score = 1'b0;
        step(2);

        pulse_score(1'b1, 1'b1);
        expect_v("tie_state", S_STATE, 2);
        expect_v("tie_p1", S_P1, 0);
        expect_v("tie_p2", S_P2, 1);
        expect_v("tie_en", S_EN, 1);
        drain();

        press_start();
        expect_v("start_in_play", S_STATE, 2);
        drain();

        hits(3);
        expect_v("spd_3hits", S_SPD, 0);
        drain();
        hits(2);
        expect_v("spd_5hits", S_SPD, SPD5);
        drain();

        pulse_score(1'b1, 1'b0);
        expect_v("p1_pts1", S_P1, 1);
        expect_v("p1_dir", S_DIR, 1);
        expect_v("p1_point", S_STATE, 3);
        expect_v("spd_in_point", S_SPD, SPD5);
        drain();
        frame();
        frame();
        expect_v("p1_serve", S_STATE, 1);
        expect_v("spd_cleared", S_SPD, 0);
        drain();
        frame();
        frame();
        frame();
        expect_v("p1_replay", S_STATE, 2);
        drain();

        pulse_score(1'b1, 1'b0);
        expect_v("win_p1_pts", S_P1, 2);
        expect_v("win_code", S_WIN, 1);
        expect_v("win_state", S_STATE, 4);
        expect_v("win_en", S_EN, 0);
        drain();
        pulse_score(1'b0, 1'b1);
        expect_v("over_p2_frozen", S_P2, 1);
        expect_v("over_hold", S_STATE, 4);
        drain();

        press_start();
        expect_v("rest_state", S_STATE, 1);
        expect_v("rest_p1", S_P1, 0);
        expect_v("rest_p2", S_P2, 0);
        expect_v("rest_win", S_WIN, 0);
        expect_v("rest_dir", S_DIR, 0);
        drain();

        frame();
        frame();
        reset = 1'b1;
        step(1);
        expect_v("midrst_state", S_STATE, 0);
        expect_v("midrst_en", S_EN, 0);
        drain();
        reset = 1'b0;
        frame();
        frame();
        frame();
        expect_v("midrst_idle", S_STATE, 0);
        expect_v("midrst_noserve", S_SCNT, 3);
        drain();

        press_start();
        frame();
        frame();
        expect_v("cnt_cleared", S_STATE, 1);
        drain();
        frame();
        expect_v("final_play", S_STATE, 2);
        expect_v("final_serves", S_SCNT, 4);
        expect_v("serve_only_play", S_BAD, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
